// File: rtl/traffic_inject_ctrl_pkg.sv
// rtl/traffic_inject_ctrl_pkg.sv - shared encodings for the traffic injection controller
package traffic_inject_ctrl_pkg;

    // Op encodings understood by the traffic source
    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_INIT = 3'd5;
    localparam logic [2:0] OP_FILL = 3'd6;
    localparam logic [2:0] OP_DEQ  = 3'd7;

    // Packet-count field carried in the Init data word
    localparam int PKT_LSB = 22;
    localparam int PKT_W   = 10;

    // Virtual-channel index width at the router input port
    localparam int VC_W_DEF = 2;

    // Session sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_FILL = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/traffic_inject_ctrl_vc_credit_bank.sv
// rtl/traffic_inject_ctrl_vc_credit_bank.sv - per-VC saturating credit counters
module vc_credit_bank #(
    parameter int NUM_VC     = 4,
    parameter int VC_W       = 2,
    parameter int MAX_CREDIT = 8,
    parameter int CREDIT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cons_valid,
    input  logic [VC_W-1:0]   cons_vc,
    input  logic              ret_valid,
    input  logic [VC_W-1:0]   ret_vc,
    output logic [NUM_VC-1:0] nonzero,
    output logic              overflow
);

    logic [CREDIT_W-1:0] r_cred [NUM_VC];
    logic [CREDIT_W-1:0] w_next [NUM_VC];
    logic [NUM_VC-1:0]   w_ovf;

    // Next count per VC: a consume and a return on the same VC cancel out,
    // and a lone return to a full counter is dropped and flagged.
    always_comb begin
        w_ovf = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            logic w_c;
            logic w_r;
            w_c = cons_valid && (cons_vc == VC_W'(i)) && (r_cred[i] != '0);
            w_r = ret_valid && (ret_vc == VC_W'(i));
            w_next[i] = r_cred[i];
            if (w_c && !w_r) begin
                w_next[i] = r_cred[i] - CREDIT_W'(1);
            end else if (w_r && !w_c) begin
                if (r_cred[i] == CREDIT_W'(MAX_CREDIT)) begin
                    w_ovf[i] = 1'b1;
                end else begin
                    w_next[i] = r_cred[i] + CREDIT_W'(1);
                end
            end
            nonzero[i] = (r_cred[i] != '0);
        end
        overflow = |w_ovf;
    end

    // Credit counters start full, mirroring an empty router buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_cred[i] <= CREDIT_W'(MAX_CREDIT);
            end
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_cred[i] <= w_next[i];
            end
        end
    end

endmodule

// File: rtl/traffic_inject_ctrl.sv
// rtl/traffic_inject_ctrl.sv - Init/Fill/Dequeue sequencer for one traffic source (option: TRAFFIC_PACING_EN)
module traffic_inject_ctrl
    import traffic_inject_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_VC     = 4,
    parameter int VC_W       = VC_W_DEF,
    parameter int MAX_CREDIT = 8,
    parameter int CREDIT_W   = 4,
    parameter int RATE_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PKT_W-1:0]  total_pkts,
    input  logic [RATE_W-1:0] inject_period,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [DATA_W-1:0] desc_data,
    input  logic [VC_W-1:0]   src_vc,
    input  logic              src_done,
    input  logic              cred_ret_valid,
    input  logic [VC_W-1:0]   cred_ret_vc,
    output logic [2:0]        op,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t             r_state;
    logic [PKT_W-1:0]   r_total;
    logic [PKT_W-1:0]   r_fill_cnt;
    logic [PKT_W-1:0]   w_fill_next;
    logic [DATA_W-1:0]  w_init_word;
    logic [NUM_VC-1:0]  w_nonzero;
    logic               w_overflow;
    logic               w_start_ok;
    logic               w_pace_ok;
    logic               w_deq;

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_fill_next = r_fill_cnt + PKT_W'(1);
    assign desc_ready  = (r_state == ST_FILL);
    assign busy        = (r_state == ST_INIT) || (r_state == ST_FILL) || (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign w_deq       = (r_state == ST_RUN) && !src_done && w_nonzero[src_vc] && w_pace_ok;

    // Init word carries the packet count in its dedicated field, zeros elsewhere
    always_comb begin
        w_init_word = '0;
        w_init_word[PKT_LSB +: PKT_W] = total_pkts;
    end

`ifdef TRAFFIC_PACING_EN
    logic [RATE_W-1:0] r_period;
    logic [RATE_W-1:0] r_pacer;

    assign w_pace_ok = (r_pacer == '0);

    // Pacer reloads on each Dequeue and counts down to the next eligible cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_pacer  <= '0;
        end else begin
            if (w_start_ok) begin
                r_period <= inject_period;
            end
            if (w_deq) begin
                r_pacer <= r_period;
            end else if (r_pacer != '0) begin
                r_pacer <= r_pacer - RATE_W'(1);
            end
        end
    end
`else
    logic w_unused_period;

    assign w_pace_ok       = 1'b1;
    assign w_unused_period = ^inject_period;
`endif

    vc_credit_bank #(
        .NUM_VC     (NUM_VC),
        .VC_W       (VC_W),
        .MAX_CREDIT (MAX_CREDIT),
        .CREDIT_W   (CREDIT_W)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .cons_valid (w_deq),
        .cons_vc    (src_vc),
        .ret_valid  (cred_ret_valid),
        .ret_vc     (cred_ret_vc),
        .nonzero    (w_nonzero),
        .overflow   (w_overflow)
    );

    // Session FSM with registered op/data toward the source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_total    <= '0;
            r_fill_cnt <= '0;
            op         <= OP_NOP;
            data       <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    op <= OP_NOP;
                    if (w_start_ok) begin
                        r_state    <= ST_INIT;
                        r_total    <= total_pkts;
                        r_fill_cnt <= '0;
                        op         <= OP_INIT;
                        data       <= w_init_word;
                    end
                end
                ST_INIT: begin
                    op      <= OP_NOP;
                    r_state <= (r_total == '0) ? ST_DONE : ST_FILL;
                end
                ST_FILL: begin
                    op <= OP_NOP;
                    if (desc_valid) begin
                        op         <= OP_FILL;
                        data       <= desc_data;
                        r_fill_cnt <= w_fill_next;
                        if (w_fill_next == r_total) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    op <= OP_NOP;
                    if (src_done) begin
                        r_state <= ST_DONE;
                    end else if (w_deq) begin
                        op <= OP_DEQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    op      <= OP_NOP;
                end
            endcase
        end
    end

    // Sticky credit-overflow flag; an overflow in the start cycle still latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (w_overflow) begin
            err <= 1'b1;
        end else if (w_start_ok) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_traffic_inject_ctrl.sv
// tb/tb_traffic_inject_ctrl.sv - self-checking bench for traffic_inject_ctrl
module tb_traffic_inject_ctrl;

`ifdef TRAFFIC_PACING_EN
    localparam bit PACE = 1'b1;
`else
    localparam bit PACE = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_INIT = 1;
    localparam int P_FILL = 2;
    localparam int P_RUN  = 3;
    localparam int P_DONE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  total_pkts;
    logic [7:0]  inject_period;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_data;
    logic [1:0]  src_vc;
    logic        src_done;
    logic        cred_ret_valid;
    logic [1:0]  cred_ret_vc;
    logic [2:0]  op;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    traffic_inject_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .total_pkts     (total_pkts),
        .inject_period  (inject_period),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_data      (desc_data),
        .src_vc         (src_vc),
        .src_done       (src_done),
        .cred_ret_valid (cred_ret_valid),
        .cred_ret_vc    (cred_ret_vc),
        .op             (op),
        .data           (data),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    int     m_phase;
    int     m_cred [4];
    int     m_total;
    int     m_filled;
    int     m_period;
    int     m_err;
    longint cyc = 0;
    longint m_next_ok;
    int     obs_op;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_IDLE;
        for (int i = 0; i < 4; i++) m_cred[i] = 8;
        m_total   = 0;
        m_filled  = 0;
        m_period  = 0;
        m_err     = 0;
        m_next_ok = 0;
    endtask

    // One clock of the reference session model, then compare the DUT after the edge
    task automatic step();
        int          e_op;
        logic [31:0] e_data;
        check("desc_ready_pre", desc_ready, m_phase == P_FILL);
        e_op   = 0;
        e_data = 0;
        case (m_phase)
            P_IDLE, P_DONE: if (start) begin
                e_op      = 5;
                e_data    = {total_pkts, 22'b0};
                m_total   = total_pkts;
                m_filled  = 0;
                m_err     = 0;
                m_period  = PACE ? int'(inject_period) : 0;
                m_phase   = P_INIT;
            end
            P_INIT: m_phase = (m_total == 0) ? P_DONE : P_FILL;
            P_FILL: if (desc_valid) begin
                e_op   = 6;
                e_data = desc_data;
                m_filled++;
                if (m_filled == m_total) m_phase = P_RUN;
            end
            P_RUN: begin
                if (src_done) begin
                    m_phase = P_DONE;
                end else if (m_cred[src_vc] > 0 && cyc >= m_next_ok) begin
                    e_op = 7;
                    m_cred[src_vc]--;
                    m_next_ok = cyc + 1 + m_period;
                end
            end
            default: ;
        endcase
        if (cred_ret_valid) begin
            if (m_cred[cred_ret_vc] >= 8) m_err = 1;
            else m_cred[cred_ret_vc]++;
        end
        cyc++;
        @(posedge clk);
        #1;
        obs_op = int'(op);
        check("op", op, e_op);
        if (e_op == 5 || e_op == 6) check("data", data, e_data);
        check("busy", busy, (m_phase == P_INIT) || (m_phase == P_FILL) || (m_phase == P_RUN));
        check("done", done, m_phase == P_DONE);
        check("err", err, m_err);
        check("desc_ready", desc_ready, m_phase == P_FILL);
    endtask

    task automatic run_count(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (obs_op == 7) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     cnt;
        int     guard;
        longint deq_cyc [$];

        rst_n = 1'b0; start = 0; total_pkts = 0; inject_period = 0;
        desc_valid = 0; desc_data = 0; src_vc = 0; src_done = 0;
        cred_ret_valid = 0; cred_ret_vc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_op", op, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_desc_ready", desc_ready, 0);
        rst_n = 1'b1;

        // Three-packet session, descriptors back-to-back
        total_pkts = 3; inject_period = 0; start = 1;
        step();
        start = 0;
        check("init_pkt_field", data[31:22], 3);
        desc_valid = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            desc_data = $urandom;
            step();
            check("fill_op", op, 6);
        end
        desc_valid = 0;
        src_vc = 0;
        step();
        check("first_deq", op, 7);

        // Credit exhaustion on VC1, then one return
        src_vc = 1;
        run_count(12, cnt);
        check("vc1_deq_count", cnt, 8);
        cred_ret_valid = 1; cred_ret_vc = 1;
        step();
        cred_ret_valid = 0;
        run_count(4, cnt);
        check("vc1_after_return", cnt, 1);

        // Drain VC0 to one credit, then return and Dequeue together
        src_vc = 0;
        repeat (6) step();
        cred_ret_valid = 1; cred_ret_vc = 0;
        step();
        check("same_cycle_deq", op, 7);
        cred_ret_valid = 0;
        step();
        check("credit_held_deq", op, 7);
        step();
        check("credit_empty_nop", op, 0);

        // Spurious return to full VC2
        cred_ret_valid = 1; cred_ret_vc = 2;
        step();
        cred_ret_valid = 0;
        check("err_set", err, 1);
        repeat (3) step();
        check("err_sticky", err, 1);
        src_vc = 2;
        run_count(10, cnt);
        check("vc2_still_full", cnt, 8);

        src_done = 1;
        step();
        src_done = 0;
        check("done_flag", done, 1);
        check("err_in_done", err, 1);

        // Zero-packet session: Init then straight to DONE, err cleared
        total_pkts = 0; start = 1;
        step();
        start = 0;
        check("err_cleared", err, 0);
        step();
        check("zero_pkts_done", done, 1);

        // Pacing session on VC3
        total_pkts = 2; inject_period = 2; start = 1;
        step();
        start = 0;
        desc_valid = 1;
        step();
        repeat (2) begin desc_data = $urandom; step(); end
        desc_valid = 0;
        src_vc = 3;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_op == 7) deq_cyc.push_back(cyc);
        end
        check("pace_deq_seen", deq_cyc.size() >= 3, 1);
        if (deq_cyc.size() >= 3) begin
            check("pace_gap1", 32'(deq_cyc[1] - deq_cyc[0]), PACE ? 3 : 1);
            check("pace_gap2", 32'(deq_cyc[2] - deq_cyc[1]), PACE ? 3 : 1);
        end
        src_done = 1;
        step();
        src_done = 0;

        // Randomized sessions checked against the model
        for (int s = 0; s < 3; s++) begin
            total_pkts = 10'($urandom_range(1, 6));
            inject_period = 8'($urandom_range(0, 3));
            start = 1;
            step();
            start = 0;
            guard = 0;
            while (m_phase != P_RUN && guard < 100) begin
                desc_valid = 1'($urandom_range(0, 1));
                desc_data = $urandom;
                step();
                guard++;
            end
            desc_valid = 0;
            check("fill_exit", desc_ready, 0);
            for (int i = 0; i < 60; i++) begin
                src_vc = 2'($urandom);
                cred_ret_valid = ($urandom_range(0, 3) == 0);
                cred_ret_vc = 2'($urandom);
                step();
            end
            cred_ret_valid = 0;
            src_done = 1;
            step();
            src_done = 0;
        end

        // Reset in the middle of FILL
        total_pkts = 5; inject_period = 0; start = 1;
        step();
        start = 0;
        desc_valid = 1;
        step();
        repeat (2) begin desc_data = $urandom; step(); end
        desc_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_op", op, 0);
        check("midrst_data", data, 0);
        check("midrst_desc_ready", desc_ready, 0);
        check("midrst_busy", busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total_pkts = 1; start = 1;
        step();
        start = 0;
        check("restart_init", op, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_inject_ctrl.md
# traffic_inject_ctrl

Sequencing controller for one traffic source in the NoC test harness. It runs the source's Init, Fill and Dequeue op protocol for a session: load the packet count, stream packet descriptors into the source, then issue Dequeue ops. Dequeues are gated by per-VC credits returned from the router input port and by an optional injection-rate pacer. It sits between the host/testbench descriptor stream and the traffic source's `op`/`data` inputs.

## Interface
- `DATA_W`, 32, width of `data`, `desc_data`, matches source data bus
- `NUM_VC`, 4, virtual channels at the router input port
- `VC_W`, 2, log2(NUM_VC)
- `MAX_CREDIT`, 8, buffer depth per VC; credit reset value
- `CREDIT_W`, 4, credit counter width (holds 0..MAX_CREDIT)
- `RATE_W`, 8, pacing period width

- Clock and reset:
  - `clk` input 1: the single clock.
  - `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: session start pulse. Ignored unless the state is IDLE or DONE.
- `total_pkts` input 10: packets in the session. Sampled on an accepted `start`.
- `inject_period` input RATE_W: minimum number of cycles between Dequeues. 0 means back-to-back. Sampled on `start`.
- `desc_valid` input 1 and `desc_ready` output 1: valid/ready pair for the descriptor stream.
- `desc_data` input DATA_W: descriptor, forwarded unchanged as Fill data.
- `src_vc` input VC_W: VC of the source's next flit.
- `src_done` input 1: the source reports all packets sent.
- `cred_ret_valid` input 1 and `cred_ret_vc` input VC_W: one credit returned by the router.
- `op` output 3: op to the source. NOP=0, Init=5, Fill=6, Dequeue=7. Registered.
- `data` output DATA_W: data to the source. Registered.
- `busy` output 1: high in every state except IDLE and DONE.
- `done` output 1: high in DONE.
- `err` output 1: sticky credit-overflow flag.

## Operation
- State IDLE:
  - `op`=NOP.
  - An accepted `start` goes to INIT.
- State INIT (one cycle):
  - `op`=Init, with `data[31:22]`=`total_pkts` and all other bits 0.
  - Next state is FILL, or DONE if `total_pkts`==0.
- State FILL:
  - `desc_ready`=1.
  - Each handshake registers `op`=Fill and `data`=`desc_data`, and increments `fill_cnt`.
  - No handshake in a cycle gives `op`=NOP.
  - When `fill_cnt` reaches `total_pkts`, go to RUN. The handshake on the last descriptor is the transition cycle.
- State RUN:
  - Dequeue is issued when `credit[src_vc]`>0, the pacer has expired, and `src_done`=0.
  - Each Dequeue decrements `credit[src_vc]` and reloads the pacer with `inject_period`.
  - When none of these conditions holds, `op`=NOP.
  - `src_done`=1 goes to DONE.
- State DONE:
  - `done`=1 and `op`=NOP.
  - `start` begins a new session (goes to INIT).
- Credits:
  - One counter per VC, reset to MAX_CREDIT.
  - A new session does not reload credits; they track the router buffer.
  - A return increments the counter for `cred_ret_vc` in any state.
  - A return and a Dequeue on the same VC in the same cycle leave the count unchanged.
  - A return to a VC already at MAX_CREDIT is dropped (the count saturates) and sets `err`.
- `err` clears only on reset or an accepted `start`.

## Timing
- Reset values: state=IDLE, `op`=0, `data`=0, `desc_ready`=0, `busy`=0, `done`=0, `err`=0, credits=MAX_CREDIT, pacer=0, `fill_cnt`=0.
- `desc_ready` is combinational from state. Descriptor accepted in cycle N gives `op`=Fill with that data in cycle N+1.
- `start` in cycle N gives `op`=Init in cycle N+1.
- The Dequeue decision uses `src_vc` and credit values from the same cycle. The credit decrement is visible in cycle N+1.
- Pacing: a Dequeue in cycle N means the next possible Dequeue is in cycle N+1+`inject_period`.
- `src_done` is acted on in the cycle it is seen. No Dequeue is issued that cycle.
- Reset asserted mid-session forces IDLE immediately (async). Outputs return to their reset values.

## Configuration
- `TRAFFIC_PACING_EN` defined: the pacer counter is instantiated and `inject_period` is honoured.
- `TRAFFIC_PACING_EN` undefined: there is no pacer and `inject_period` is ignored. A Dequeue is eligible every cycle that credit is available.

## Structure
- Shared parameters package or include holds:
  - op encodings (NOP/Init/Fill/Dequeue);
  - the `total_pkts` field position [31:22];
  - FSM state encodings;
  - VC width.
- One sub-module: `vc_credit_bank`.
  - Holds the NUM_VC saturating credit counters.
  - Provides a consume port and a return port.
  - Flags overflow.
  - Outputs a per-VC nonzero vector.

## Test plan
- Reset, then `start` with `total_pkts`=3 and 3 descriptors back-to-back:
  - `op` sequence is Init, Fill, Fill, Fill, then Dequeue.
  - Init `data[31:22]`=3.
  - `busy`=1 throughout.
- Credit exhaustion: `src_vc`=1 held, no returns, `inject_period`=0:
  - exactly 8 Dequeues are issued, then NOP;
  - one `cred_ret` on VC1 gives one more Dequeue.
- Pacing with `inject_period`=2 and unlimited credit: Dequeues in cycles N, N+3, N+6.
- Same-cycle return and Dequeue on VC0 at credit 1: credit stays at 1 and the Dequeue is issued.
- Spurious return to a full VC2: credit stays at 8 and `err`=1 until the next `start`.
- Reset during FILL after 2 of 5 descriptors:
  - IDLE with `op`=0 and `desc_ready`=0 immediately;
  - a new `start` gives Init.
